ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 45 ++++
 rtl/ram_arbiter.sv | 153 +++++++++++++++
 tb/tb_ram_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: instruction port, data port and the attached RAM.
// slave is the arbiter's view; master is the view of the requesters/RAM model.
interface ram_arbiter_if;
  // Instruction port
  logic        i_req_valid;
  logic        i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] i_rsp_data;
  logic        i_rsp_err;
  // Data port
  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_req_write;
  logic        d_rsp_valid;
  logic        d_rsp_ready;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;
  // RAM side
  logic [31:0] ram_address;
  logic [31:0] ram_input_data;
  logic        ram_should_write;
  logic [31:0] ram_output_data;

  modport slave (
    input  i_req_valid, i_req_addr, i_rsp_ready,
    input  d_req_valid, d_req_addr, d_req_wdata, d_req_write, d_rsp_ready,
    input  ram_output_data,
    output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output ram_address, ram_input_data, ram_should_write
  );

  modport master (
    output i_req_valid, i_req_addr, i_rsp_ready,
    output d_req_valid, d_req_addr, d_req_wdata, d_req_write, d_rsp_ready,
    output ram_output_data,
    input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input  ram_address, ram_input_data, ram_should_write
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-ported 32-bit RAM.
// One transaction at a time: IDLE (grant) -> ACCESS (RAM cycle) -> RESP (hold until taken).
// Define RAM_ARBITER_ROUND_ROBIN_EN to alternate grants on conflicts; otherwise data wins.
module ram_arbiter #(
  parameter int unsigned SIZE_WORDS = 256
) (
  input logic          clock,
  input logic          reset_n,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic        PortInstr = 1'b0;
  localparam logic        PortData  = 1'b1;
  localparam logic [31:0] AddrLimit = 32'(4 * SIZE_WORDS);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic req_any;
  logic grant_data;
  logic access_err;
  logic rsp_fire;

  assign req_any    = bus.i_req_valid | bus.d_req_valid;
  assign access_err = (addr_q[1:0] != 2'b00) || (addr_q >= AddrLimit);
  assign rsp_fire   = (state_q == StResp) &
                      ((owner_q == PortData) ? bus.d_rsp_ready : bus.i_rsp_ready);

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  logic last_q, last_d;

  // On a conflict the port that did not win last time is granted.
  always_comb begin
    grant_data = bus.d_req_valid & (~bus.i_req_valid | (last_q == PortInstr));
    last_d     = last_q;
    if (state_q == StIdle && req_any) last_d = grant_data;
  end

  // Last-grant register; reset favours the instruction port on the first conflict.
  always_ff @(posedge clock) begin
    if (!reset_n) last_q <= PortData;
    else          last_q <= last_d;
  end
`else
  // Fixed priority: data port wins any conflict.
  always_comb begin
    grant_data = bus.d_req_valid;
  end
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_any) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   if (rsp_fire) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Request latch on accept and response capture at the end of ACCESS.
  always_comb begin
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    if (state_q == StIdle && req_any) begin
      owner_d = grant_data;
      addr_d  = grant_data ? bus.d_req_addr : bus.i_req_addr;
      wdata_d = grant_data ? bus.d_req_wdata : 32'h0;
      write_d = grant_data & bus.d_req_write;
    end
    if (state_q == StAccess) begin
      rsp_err_d  = access_err;
      rsp_data_d = (access_err | write_q) ? 32'h0 : bus.ram_output_data;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      owner_q    <= PortData;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      write_q    <= 1'b0;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Outputs decoded from state; write enable also gated by reset so an aborted
  // ACCESS never reaches the RAM's falling-edge write.
  always_comb begin
    bus.i_req_ready      = 1'b0;
    bus.d_req_ready      = 1'b0;
    bus.i_rsp_valid      = 1'b0;
    bus.i_rsp_data       = 32'h0;
    bus.i_rsp_err        = 1'b0;
    bus.d_rsp_valid      = 1'b0;
    bus.d_rsp_data       = 32'h0;
    bus.d_rsp_err        = 1'b0;
    bus.ram_address      = 32'h0;
    bus.ram_input_data   = 32'h0;
    bus.ram_should_write = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.i_req_ready = bus.i_req_valid & ~grant_data;
        bus.d_req_ready = grant_data;
      end
      StAccess: begin
        bus.ram_address      = addr_q;
        bus.ram_input_data   = wdata_q;
        bus.ram_should_write = write_q & ~access_err & reset_n;
      end
      StResp: begin
        if (owner_q == PortData) begin
          bus.d_rsp_valid = 1'b1;
          bus.d_rsp_data  = rsp_data_q;
          bus.d_rsp_err   = rsp_err_q;
        end else begin
          bus.i_rsp_valid = 1'b1;
          bus.i_rsp_data  = rsp_data_q;
          bus.i_rsp_err   = rsp_err_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a response scoreboard and a behavioural RAM.
module tb_ram_arbiter;

  typedef struct {
    logic        port;  // 0 = instruction, 1 = data
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_t        sb[$];
  logic [31:0] model[256];
  logic [31:0] mem[256];
  bit          mem_init = 1'b0;
  logic        last_model;

  ram_arbiter_if bus();

  ram_arbiter #(.SIZE_WORDS(256)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // RAM: combinational read, falling-edge write.
  assign bus.ram_output_data = mem[bus.ram_address[9:2]];
  always @(negedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
      mem_init = 1'b1;
    end else if (bus.ram_should_write) begin
      mem[bus.ram_address[9:2]] = bus.ram_input_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_winner();
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    return (last_model == 1'b1) ? 1'b0 : 1'b1;
`else
    return 1'b1;
`endif
  endfunction

  // Pop the oldest expectation and compare against whichever response is valid.
  task automatic check_rsp();
    exp_t e;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("i_rsp_valid", 32'(bus.i_rsp_valid), 32'(e.port == 1'b0));
      chk("d_rsp_valid", 32'(bus.d_rsp_valid), 32'(e.port == 1'b1));
      chk("rsp_data", e.port ? bus.d_rsp_data : bus.i_rsp_data, e.data);
      chk("rsp_err", 32'(e.port ? bus.d_rsp_err : bus.i_rsp_err), 32'(e.err));
    end
  endtask

  // One transaction on a single port; response checked exactly at accept+2, held for
  // 'hold' cycles with rsp_ready low. poke raises an instruction read during the access.
  task automatic run_txn(input logic port, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic wr, input int hold, input bit poke);
    exp_t e;
    logic err;
    int   n;
    err    = (addr[1:0] != 2'b00) || (addr >= 32'h400);
    e.port = port;
    e.err  = err;
    e.data = (err || wr) ? 32'h0 : model[addr[9:2]];
    if (port) begin
      bus.d_req_valid = 1'b1; bus.d_req_addr = addr;
      bus.d_req_wdata = wdata; bus.d_req_write = wr;
    end else begin
      bus.i_req_valid = 1'b1; bus.i_req_addr = addr;
    end
    #1;
    n = 0;
    while (!(port ? bus.d_req_ready : bus.i_req_ready) && n < 20) begin
      tick();
      n++;
    end
    chk("grant_wait", 32'(n < 20), 32'd1);
    sb.push_back(e);
    last_model = port;
    if (wr && !err) model[addr[9:2]] = wdata;
    tick();  // ACCESS
    if (port) bus.d_req_valid = 1'b0;
    else      bus.i_req_valid = 1'b0;
    if (poke) begin
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = 32'h10;
    end
    #1;
    chk("ram_we", 32'(bus.ram_should_write), 32'(wr && !err));
    chk("ram_addr", bus.ram_address, addr);
    if (wr) chk("ram_wdata", bus.ram_input_data, wdata);
    tick();  // RESP
    check_rsp();
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_valid", 32'(port ? bus.d_rsp_valid : bus.i_rsp_valid), 32'd1);
      chk("hold_data", port ? bus.d_rsp_data : bus.i_rsp_data, e.data);
      chk("hold_err", 32'(port ? bus.d_rsp_err : bus.i_rsp_err), 32'(e.err));
      chk("hold_i_ready", 32'(bus.i_req_ready), 32'd0);
    end
    if (port) bus.d_rsp_ready = 1'b1;
    else      bus.i_rsp_ready = 1'b1;
    tick();  // back in IDLE
    bus.d_rsp_ready = 1'b0;
    bus.i_rsp_ready = 1'b0;
    chk("post_hs_valid", 32'(bus.i_rsp_valid | bus.d_rsp_valid), 32'd0);
  endtask

  // Both ports requesting reads (instr 0x10, data 0x14): one grant/response round.
  task automatic arb_round();
    exp_t e;
    e.port = exp_winner();
    e.err  = 1'b0;
    e.data = e.port ? model[5] : model[4];
    #1;
    chk("arb_i_ready", 32'(bus.i_req_ready), 32'(e.port == 1'b0));
    chk("arb_d_ready", 32'(bus.d_req_ready), 32'(e.port == 1'b1));
    sb.push_back(e);
    last_model = e.port;
    tick();  // ACCESS
    chk("arb_access_ready", 32'(bus.i_req_ready | bus.d_req_ready), 32'd0);
    tick();  // RESP
    check_rsp();
    bus.i_rsp_ready = 1'b1;
    bus.d_rsp_ready = 1'b1;
    tick();
    bus.i_rsp_ready = 1'b0;
    bus.d_rsp_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = 32'hA500_0000 | 32'(i);
    last_model      = 1'b1;
    bus.i_req_valid = 1'b0; bus.i_req_addr  = 32'h0; bus.i_rsp_ready = 1'b0;
    bus.d_req_valid = 1'b0; bus.d_req_addr  = 32'h0; bus.d_req_wdata = 32'h0;
    bus.d_req_write = 1'b0; bus.d_rsp_ready = 1'b0;

    // Reset
    repeat (3) tick();
    chk("rst_i_rsp_valid", 32'(bus.i_rsp_valid), 32'd0);
    chk("rst_d_rsp_valid", 32'(bus.d_rsp_valid), 32'd0);
    chk("rst_d_rsp_data", bus.d_rsp_data, 32'h0);
    chk("rst_ram_we", 32'(bus.ram_should_write), 32'd0);
    chk("rst_ram_addr", bus.ram_address, 32'h0);
    reset_n = 1'b1;
    tick();

    // Conflicting requests from reset
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h10;
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h14; bus.d_req_write = 1'b0;
    for (int r = 0; r < 4; r++) arb_round();
    bus.i_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
    tick();

    // Write then read back through the other port
    run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 0, 1'b0);
    run_txn(1'b0, 32'h0000_0010, 32'h0, 1'b0, 0, 1'b0);
    chk("mem_word4", mem[4], 32'hDEAD_BEEF);

    // Misaligned and out-of-range writes
    run_txn(1'b1, 32'h0000_0402, 32'h1111_2222, 1'b1, 0, 1'b0);
    run_txn(1'b1, 32'h0000_0400, 32'h3333_4444, 1'b1, 0, 1'b0);
    chk("mem_word0", mem[0], model[0]);

    // Back-pressure with an instruction request pending; it is served next
    run_txn(1'b1, 32'h0000_0014, 32'h0, 1'b0, 5, 1'b1);
    #1;
    chk("pending_i_ready", 32'(bus.i_req_ready), 32'd1);
    run_txn(1'b0, 32'h0000_0010, 32'h0, 1'b0, 0, 1'b0);

    // Reset during ACCESS of a write
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h20;
    bus.d_req_wdata = 32'h1234_5678; bus.d_req_write = 1'b1;
    #1;
    chk("abort_grant", 32'(bus.d_req_ready), 32'd1);
    tick();  // ACCESS
    bus.d_req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("abort_ram_we", 32'(bus.ram_should_write), 32'd0);
    tick();
    tick();
    chk("abort_d_rsp_valid", 32'(bus.d_rsp_valid), 32'd0);
    reset_n = 1'b1;
    last_model = 1'b1;
    tick();
    chk("abort_no_rsp", 32'(bus.i_rsp_valid | bus.d_rsp_valid), 32'd0);
    chk("abort_mem_word8", mem[8], model[8]);
    run_txn(1'b1, 32'h0000_0020, 32'h0, 1'b0, 0, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
